// File: rtl/axil_read_arbiter.sv
// axil_read_arbiter
// Round-robin arbiter that shares one AXI-Lite read master (AR + R) among
// NUM_REQ local requesters. Each grant runs one complete read: address
// phase, data phase, then a single response cycle with a done pulse to the
// owner. All outputs come straight from flops.
module axil_read_arbiter #(
    parameter int          NUM_REQ  = 4,
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter logic [3:0]  AR_CACHE = 4'b0011
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [1:0]                rsp_resp,
    output logic                      busy,
    output logic [ADDR_W-1:0]         araddr,
    output logic [3:0]                arcache,
    output logic [2:0]                arprot,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [DATA_W-1:0]         rdata,
    input  logic [1:0]                rresp,
    input  logic                      rvalid,
    output logic                      rready
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;   // highest-priority requester for the next arbitration
    logic [PTR_W-1:0]   owner;    // index of the requester that holds the current grant

    logic [PTR_W-1:0]   pick;     // arbitration winner, valid when any req bit is set
    logic [PTR_W:0]     cand;
    logic [PTR_W-1:0]   idx;
    logic               found;
    logic [ADDR_W-1:0]  sel_addr;

    // The AXI protection attribute is fixed: unprivileged, secure, data access.
    assign arprot = 3'b000;

    // Round-robin scan: first set req bit at or above rr_ptr, wrapping to 0.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write so no latch is inferred.
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            idx = cand[PTR_W-1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Address of the requester that wins this arbitration.
    assign sel_addr = req_addr[pick*ADDR_W +: ADDR_W];

    // Transaction sequencer: grant, AR handshake, R handshake, response cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the response data registers are reset too, since they are visible outputs with a defined reset value.
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            grant    <= '0;
            done     <= '0;
            busy     <= 1'b0;
            araddr   <= '0;
            arcache  <= 4'b0000;
            arvalid  <= 1'b0;
            rready   <= 1'b0;
            rsp_data <= '0;
            rsp_resp <= 2'b00;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            case (state)
                IDLE: begin
                    if (found) begin
                        owner   <= pick;
                        grant   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                        araddr  <= {sel_addr[ADDR_W-1:2], 2'b00};
                        arvalid <= 1'b1;
                        arcache <= AR_CACHE;
                        busy    <= 1'b1;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    // arvalid is always 1 here, so arready alone completes the handshake.
                    if (arready) begin
                        arvalid <= 1'b0;
                        arcache <= 4'b0000;
                        rready  <= 1'b1;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    // rready is always 1 here; rvalid in any other state is never accepted.
                    if (rvalid) begin
                        rsp_data <= rdata;
                        rsp_resp <= rresp;
                        rready   <= 1'b0;
                        done     <= grant;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    done   <= '0;
                    grant  <= '0;
                    busy   <= 1'b0;
                    rr_ptr <= (owner == PTR_W'(NUM_REQ-1)) ? '0 : owner + 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_read_arbiter.sv
// tb_axil_read_arbiter
// Directed, table-driven bench for axil_read_arbiter with NUM_REQ=4,
// ADDR_W=DATA_W=32, plus hand-written reset sequences.
module tb_axil_read_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         rsp_data;
    logic [1:0]                rsp_resp;
    logic                      busy;
    logic [ADDR_W-1:0]         araddr;
    logic [3:0]                arcache;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;
    logic [DATA_W-1:0]         rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    axil_read_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .AR_CACHE (4'b0011)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .grant    (grant),
        .done     (done),
        .rsp_data (rsp_data),
        .rsp_resp (rsp_resp),
        .busy     (busy),
        .araddr   (araddr),
        .arcache  (arcache),
        .arprot   (arprot),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  exp_grant;
        logic [31:0] exp_addr;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          ar_delay;
        int          r_delay;
        bit          drop_req;
    } vec_t;

    localparam logic [NUM_REQ*ADDR_W-1:0] BASE_ADDR =
        {32'hFFFF_FFFE, 32'h0000_1237, 32'h2000_0005, 32'h1000_0003};

    vec_t vecs [11];
    int   n_pass;
    int   n_total;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one full read for vector v, checking every cycle of the exchange.
    task automatic run_txn(input string tag, input vec_t v);
        int n;
        int own;
        own = 0;
        for (int b = 0; b < NUM_REQ; b++) if (v.exp_grant[b]) own = b;
        req     = v.req;
        arready = 1'b0;
        rvalid  = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!arvalid && n < 8);
        check({tag, "_ar_latency"}, 64'(n), 64'd1);
        check({tag, "_grant"}, 64'(grant), 64'(v.exp_grant));
        check({tag, "_araddr"}, 64'(araddr), 64'(v.exp_addr));
        check({tag, "_arcache"}, 64'(arcache), 64'h3);
        check({tag, "_busy_rready_prot"}, {busy, rready, arprot}, {1'b1, 1'b0, 3'b000});
        if (v.drop_req) begin
            req = '0;
            req_addr[own*ADDR_W +: ADDR_W] = 32'h5555_5555;
        end
        for (int c = 0; c < v.ar_delay; c++) begin
            rvalid = 1'b1;
            rdata  = 32'hBAD0_BAD0;
            rresp  = 2'b11;
            @(negedge clk);
            check($sformatf("%s_ar_hold%0d", tag, c), {arvalid, rready, done, araddr},
                  {1'b1, 1'b0, 4'b0000, v.exp_addr});
        end
        arready = 1'b1;
        rvalid  = 1'b0;
        @(negedge clk);
        check({tag, "_ar_hs"}, {arvalid, rready, arcache}, {1'b0, 1'b1, 4'b0000});
        // arready while arvalid is low must be ignored.
        arready = (v.ar_delay > 0);
        for (int c = 0; c < v.r_delay; c++) begin
            @(negedge clk);
            check($sformatf("%s_r_wait%0d", tag, c), {arvalid, rready, done, grant},
                  {1'b0, 1'b1, 4'b0000, v.exp_grant});
        end
        rvalid  = 1'b1;
        rdata   = v.rdata;
        rresp   = v.rresp;
        arready = 1'b0;
        @(negedge clk);
        check({tag, "_done"}, 64'(done), 64'(v.exp_grant));
        check({tag, "_rsp_data"}, 64'(rsp_data), 64'(v.rdata));
        check({tag, "_rsp_resp"}, 64'(rsp_resp), 64'(v.rresp));
        check({tag, "_resp_cycle"}, {rready, arvalid, grant, busy}, {1'b0, 1'b0, v.exp_grant, 1'b1});
        rvalid = 1'b0;
        rdata  = 32'h0;
        @(negedge clk);
        check({tag, "_idle"}, {done, grant, busy, rready, arvalid}, {4'b0000, 4'b0000, 3'b000});
        check({tag, "_rsp_held"}, 64'(rsp_data), 64'(v.rdata));
        req      = '0;
        req_addr = BASE_ADDR;
    endtask

    initial begin
        int n;
        vec_t post;
        n_pass   = 0;
        n_total  = 0;
        reset    = 1'b0;
        req      = 4'b1111;
        req_addr = BASE_ADDR;
        arready  = 1'b0;
        rvalid   = 1'b0;
        rdata    = '0;
        rresp    = 2'b00;

        //        req      grant    exp_addr       rdata          rresp ar r  drop
        vecs[0] = '{4'b1111, 4'b0001, 32'h1000_0000, 32'h0000_0001, 2'b00, 0, 0, 1'b0};
        vecs[1] = '{4'b1111, 4'b0010, 32'h2000_0004, 32'h0000_0002, 2'b00, 0, 0, 1'b0};
        vecs[2] = '{4'b1111, 4'b0100, 32'h0000_1234, 32'h0000_0003, 2'b00, 0, 0, 1'b0};
        vecs[3] = '{4'b1111, 4'b1000, 32'hFFFF_FFFC, 32'h0000_0004, 2'b00, 0, 0, 1'b0};
        vecs[4] = '{4'b1111, 4'b0001, 32'h1000_0000, 32'h0000_0005, 2'b00, 0, 0, 1'b0};
        vecs[5] = '{4'b0100, 4'b0100, 32'h0000_1234, 32'hDEAD_BEEF, 2'b00, 0, 0, 1'b0};
        vecs[6] = '{4'b0011, 4'b0001, 32'h1000_0000, 32'hCAFE_0006, 2'b10, 0, 0, 1'b0};
        vecs[7] = '{4'b0011, 4'b0010, 32'h2000_0004, 32'hCAFE_0007, 2'b11, 2, 1, 1'b1};
        vecs[8] = '{4'b1001, 4'b1000, 32'hFFFF_FFFC, 32'h1234_5678, 2'b00, 5, 3, 1'b0};
        vecs[9] = '{4'b0010, 4'b0010, 32'h2000_0004, 32'hA5A5_5A5A, 2'b01, 0, 0, 1'b0};

        // Reset held with all requests active: every output stays at zero.
        repeat (3) @(negedge clk);
        check("rst_grant_done", {grant, done}, 8'h00);
        check("rst_axi", {arvalid, rready, arcache, araddr}, 38'h0);
        check("rst_rsp_busy", {rsp_data, rsp_resp, busy}, 35'h0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_txn($sformatf("v%0d", i), vecs[i]);
        end

        // Reset asserted mid-transaction in DATA; rr_ptr is 2 here, so req0 wins.
        req = 4'b0001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!arvalid && n < 8);
        check("mid_grant", 64'(grant), 64'h1);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check("mid_in_data", {rready, arvalid}, 2'b10);
        #2;
        reset  = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'h7777_7777;
        #1;
        check("mid_rst_async", {arvalid, rready, grant, busy, done}, 11'h0);
        check("mid_rst_regs", {araddr, rsp_data, rsp_resp}, 66'h0);
        @(negedge clk);
        check("mid_rst_no_done", 64'(done), 64'h0);
        reset  = 1'b1;
        rvalid = 1'b0;
        req    = '0;
        @(negedge clk);
        check("mid_rst_idle", {done, busy, rsp_data}, 37'h0);

        // rr_ptr back at 0: req0 wins against all four (rr_ptr=2 would pick req2).
        post = '{4'b1111, 4'b0001, 32'h1000_0000, 32'h0BAD_F00D, 2'b00, 0, 0, 1'b0};
        run_txn("post_rst", post);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute time guard so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule
